// File: rtl/operand_stream_pkg.sv
// Shared types for the operand stream generator: operand modes, FSM states, default LFSR feedback.
package operand_stream_pkg;

    typedef enum logic [1:0] {
        MODE_LFSR  = 2'b00,
        MODE_CONST = 2'b01,
        MODE_RAMP  = 2'b10,
        MODE_ZERO  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // x^32 + x^22 + x^2 + x + 1, Galois form
    localparam logic [31:0] DEFAULT_POLY = 32'h80200003;

endpackage

// File: rtl/galois_lfsr_step.sv
// One combinational Galois LFSR advance: y = (x >> 1) ^ (x[0] ? POLY : 0).
module galois_lfsr_step #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h80200003)
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = (x >> 1) ^ (x[0] ? POLY : '0);

endmodule

// File: rtl/operand_stream_gen.sv
// Operand triple source (LFSR / CONST / RAMP / ZERO) over valid/ready with run status.
// Optional inter-triple gap enabled by defining OPERAND_STREAM_GEN_GAP_EN.
module operand_stream_gen
    import operand_stream_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'(DEFAULT_POLY),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(200),
    parameter int               COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] count,
    input  logic [1:0]         mode,
`ifdef OPERAND_STREAM_GEN_GAP_EN
    input  logic [3:0]         gap,
`endif
    input  logic               ready,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   c,
    output logic               valid,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] issued
);

    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    state_e             state;
    mode_e              mode_r;
    logic [COUNT_W-1:0] count_r;
    // lfsr and k hold the values the *next* presented triple is built from
    logic [WIDTH-1:0]   lfsr;
    logic [WIDTH-1:0]   k;

    logic               xfer;
    logic               last;
    logic               start_go;
    logic               load;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   s1;
    logic [WIDTH-1:0]   s2;
    logic [WIDTH-1:0]   s3;
    logic [WIDTH-1:0]   kx;
    logic [WIDTH-1:0]   na;
    logic [WIDTH-1:0]   nb;
    logic [WIDTH-1:0]   nc;
    mode_e              ld_mode;

    assign xfer     = valid && ready;
    assign last     = (issued + 1'b1) == count_r;
    assign start_go = (state == IDLE) && start;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

`ifdef OPERAND_STREAM_GEN_GAP_EN
    logic [3:0] gap_r;
    logic [3:0] gcnt;
    logic       gap_end;

    assign gap_end = (state == RUN) && (gcnt == 4'd1);
    assign load    = (start_go && count != '0)
                   || ((state == RUN) && xfer && !last && gap_r == 4'd0)
                   || gap_end;
`else
    assign load    = (start_go && count != '0)
                   || ((state == RUN) && xfer && !last);
`endif

    galois_lfsr_step #(.WIDTH(WIDTH), .POLY(LFSR_POLY)) u_step_b (.x(x),  .y(s1));
    galois_lfsr_step #(.WIDTH(WIDTH), .POLY(LFSR_POLY)) u_step_c (.x(s1), .y(s2));
    galois_lfsr_step #(.WIDTH(WIDTH), .POLY(LFSR_POLY)) u_step_n (.x(s2), .y(s3));

    // A new run rebuilds its first triple from the seed and the freshly sampled mode
    always_comb begin
        x       = start_go ? SEED_EFF : lfsr;
        kx      = start_go ? '0 : k;
        ld_mode = start_go ? mode_e'(mode) : mode_r;
        na      = '0;
        nb      = '0;
        nc      = '0;
        case (ld_mode)
            MODE_LFSR: begin
                na = x;
                nb = s1;
                nc = s2;
            end
            MODE_CONST: begin
                na = SEED_EFF;
                nb = SEED_EFF;
                nc = SEED_EFF;
            end
            MODE_RAMP: begin
                na = kx;
                nb = kx + WIDTH'(1);
                nc = kx + WIDTH'(2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mode_r  <= MODE_LFSR;
            count_r <= '0;
            issued  <= '0;
            lfsr    <= SEED_EFF;
            k       <= '0;
            a       <= '0;
            b       <= '0;
            c       <= '0;
            valid   <= 1'b0;
`ifdef OPERAND_STREAM_GEN_GAP_EN
            gap_r   <= '0;
            gcnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count_r <= count;
                        mode_r  <= mode_e'(mode);
                        issued  <= '0;
`ifdef OPERAND_STREAM_GEN_GAP_EN
                        gap_r   <= gap;
                        gcnt    <= '0;
`endif
                        state   <= (count == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        issued <= issued + 1'b1;
                        if (last) begin
                            state <= DONE;
                            valid <= 1'b0;
                        end
`ifdef OPERAND_STREAM_GEN_GAP_EN
                        else if (gap_r != 4'd0) begin
                            valid <= 1'b0;
                            gcnt  <= gap_r;
                        end
`endif
                    end
`ifdef OPERAND_STREAM_GEN_GAP_EN
                    if (gcnt != 4'd0) begin
                        gcnt <= gcnt - 4'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                a     <= na;
                b     <= nb;
                c     <= nc;
                valid <= 1'b1;
                lfsr  <= s3;
                k     <= kx + WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_operand_stream_gen.sv
// Randomized/directed bench for operand_stream_gen against an index-based reference model.
module tb_operand_stream_gen;

    localparam int W  = 32;
    localparam int CW = 16;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          ready = 1'b0;
    logic [CW-1:0] count = '0;
    logic [1:0]    mode  = 2'b00;
`ifdef OPERAND_STREAM_GEN_GAP_EN
    logic [3:0]    gap   = 4'd0;
`endif

    logic [W-1:0]  a0, b0, c0, a1, b1, c1;
    logic          valid0, busy0, done0, valid1, busy1, done1;
    logic [CW-1:0] issued0, issued1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    operand_stream_gen u_dut (
        .clk(clk), .rst(rst), .start(start), .count(count), .mode(mode),
`ifdef OPERAND_STREAM_GEN_GAP_EN
        .gap(gap),
`endif
        .ready(ready), .a(a0), .b(b0), .c(c0),
        .valid(valid0), .busy(busy0), .done(done0), .issued(issued0)
    );

    operand_stream_gen #(.SEED(32'd1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .count(count), .mode(mode),
`ifdef OPERAND_STREAM_GEN_GAP_EN
        .gap(gap),
`endif
        .ready(ready), .a(a1), .b(b1), .c(c1),
        .valid(valid1), .busy(busy1), .done(done1), .issued(issued1)
    );

    task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
    endfunction

    // Triple number i of a run: LFSR walks 3*i single steps from the seed
    function automatic logic [95:0] ref_triple(input int m, input logic [31:0] seed, input int i);
        logic [31:0] s;
        logic [31:0] kk;
        s  = seed;
        kk = i;
        for (int j = 0; j < 3 * i; j++) s = step(s);
        case (m)
            0:       return {s, step(s), step(step(s))};
            1:       return {seed, seed, seed};
            2:       return {kk, kk + 32'd1, kk + 32'd2};
            default: return 96'd0;
        endcase
    endfunction

    task automatic chk_status(input string tag, input logic v, input logic bz, input logic dn, input int iss);
        chk({tag, ".valid"},  96'(valid0),  96'(v));
        chk({tag, ".busy"},   96'(busy0),   96'(bz));
        chk({tag, ".done"},   96'(done0),   96'(dn));
        chk({tag, ".issued"}, 96'(issued0), 96'(iss));
        chk({tag, ".st1"},    96'({valid1, busy1, done1, issued1}), 96'({v, bz, dn, CW'(iss)}));
    endtask

    // rdy_mode: 0 always ready, 1 random, 2 pattern 1,0,0. stop_at>0 returns after that many transfers.
    task automatic run(input int m, input int cnt, input int rdy_mode, input int stop_at);
        int i   = 0;
        int cyc = 0;
        @(negedge clk);
        start = 1'b1;
        count = CW'(cnt);
        mode  = 2'(m);
        @(negedge clk);
        start = 1'b0;
        count = CW'($urandom);
        mode  = 2'($urandom_range(0, 3));
        if (cnt == 0) begin
            chk_status("zero_run", 1'b0, 1'b1, 1'b1, 0);
            @(negedge clk);
            chk_status("zero_idle", 1'b0, 1'b0, 1'b0, 0);
            return;
        end
        while (i < cnt && cyc < 400) begin
            if (stop_at > 0 && i == stop_at) return;
            case (rdy_mode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                default: ready = (cyc % 3 == 0);
            endcase
            chk_status("run", 1'b1, 1'b1, 1'b0, i);
            chk("trip", {a0, b0, c0}, ref_triple(m, 32'd200, i));
            chk("trip_s1", {a1, b1, c1}, ref_triple(m, 32'd1, i));
            if (ready) i++;
            cyc++;
            @(negedge clk);
        end
        ready = 1'b0;
        if (cyc >= 400) chk("timeout", 96'(cyc), 96'(0));
        chk_status("done", 1'b0, 1'b1, 1'b1, cnt);
        chk("hold", {a0, b0, c0}, ref_triple(m, 32'd200, cnt - 1));
        @(negedge clk);
        chk_status("idle", 1'b0, 1'b0, 1'b0, cnt);
        chk("hold_idle", {a0, b0, c0}, ref_triple(m, 32'd200, cnt - 1));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_status("reset", 1'b0, 1'b0, 1'b0, 0);
        chk("reset.abc", {a0, b0, c0}, 96'd0);
        rst = 1'b0;

        run(0, 0, 0, 0);
        run(2, 3, 0, 0);
        run(0, 1, 0, 0);
        chk("lfsr_seed1", {a1, b1, c1}, {32'h00000001, 32'h80200003, 32'hC0300002});
        run(1, 4, 2, 0);
        run(0, 5, 2, 0);

        // reset mid-run after two transfers, then a clean RAMP run
        run(2, 8, 0, 2);
        rst = 1'b1;
        #1;
        chk_status("midrst", 1'b0, 1'b0, 1'b0, 0);
        chk("midrst.abc", {a0, b0, c0}, 96'd0);
        @(negedge clk);
        rst = 1'b0;
        run(2, 3, 0, 0);

        for (int r = 0; r < 10; r++) begin
            run($urandom_range(0, 3), $urandom_range(1, 10), 1, 0);
        end

`ifdef OPERAND_STREAM_GEN_GAP_EN
        @(negedge clk);
        gap   = 4'd2;
        start = 1'b1;
        count = CW'(2);
        mode  = 2'd2;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        gap   = 4'd0;
        chk("gap.v0", 96'(valid0), 96'(1));
        chk("gap.t0", {a0, b0, c0}, ref_triple(2, 32'd200, 0));
        @(negedge clk);
        chk("gap.v1", 96'(valid0), 96'(0));
        @(negedge clk);
        chk("gap.v2", 96'(valid0), 96'(0));
        @(negedge clk);
        chk("gap.v3", 96'(valid0), 96'(1));
        chk("gap.t1", {a0, b0, c0}, ref_triple(2, 32'd200, 1));
        @(negedge clk);
        ready = 1'b0;
        chk_status("gap.done", 1'b0, 1'b1, 1'b1, 2);
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_stream_gen.md
Name: operand_stream_gen

Overview:
- Synthesizable operand source that sits directly upstream of the `hierarchical` arithmetic block and drives its `a`, `b` and `c` operands.
- Produces a programmed number of operand triples over a valid/ready handshake.
- Deterministic patterns (LFSR, constant, ramp) give reproducible switching activity for VCD-based power estimation, without bench-side `$random` stimulus.
- Done/issued status lets a bench or top-level sequence runs.

Parameters:
- WIDTH, 32, operand width; also the LFSR width.
- LFSR_POLY, 32'h80200003, Galois feedback mask (x^32+x^22+x^2+x+1); WIDTH bits wide.
- SEED, 32'd200, LFSR/constant initial value; zero is replaced by 1.
- COUNT_W, 16, width of the triple counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- count  in  COUNT_W  number of triples to issue; latched on start.
- mode  in  2  00 LFSR, 01 CONST, 10 RAMP, 11 ZERO; latched on start.
- ready  in  1  downstream accepts the current triple.
- a  out  WIDTH  operand a.
- b  out  WIDTH  operand b.
- c  out  WIDTH  operand c.
- valid  out  1  triple on a/b/c is valid.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at end of run.
- issued  out  COUNT_W  triples transferred in the current/last run.

Behaviour:
- Reset values (async assert, sync-safe deassert): state=IDLE; a=b=c=0; valid=0; busy=0; done=0; issued=0; lfsr=SEED (or 1 if SEED==0); ramp k=0.
- States and transitions:
  - IDLE -> RUN on start. Latch count/mode, clear issued, set k=0, lfsr=seed.
  - IDLE -> DONE on start with count==0.
  - RUN -> DONE on the transfer that makes issued==count.
  - DONE -> IDLE after one cycle; done=1 only in DONE.
- Transfer = valid && ready on a clock edge.
- Latency: start sampled at edge N; valid=1 with the first triple from edge N+1.
- Back-to-back: the next triple is presented the cycle after a transfer; valid stays high.
- Stability: while valid && !ready, a/b/c/valid hold unchanged.
- Mode patterns, with s = lfsr and step(x) = (x>>1) ^ (x[0] ? LFSR_POLY : 0):
  - LFSR: a=s, b=step(s), c=step(step(s)); on transfer s <= step^3(s).
  - CONST: a=b=c=seed for the whole run.
  - RAMP: a=k, b=k+1, c=k+2, all mod 2^WIDTH; k increments on transfer; wrap 2^WIDTH-1 -> 0 silently.
  - ZERO: all 0.
- Outputs a/b/c are registered; all three LFSR steps are combinational from s.
- issued increments per transfer; it is not cleared at the end of a run. issued is a count of completed transfers; count==0 runs therefore end with issued==0.
- When valid is 0, a/b/c hold the last presented values (no toggling while idle).
- Simultaneous events: start while busy is ignored; count/mode changes mid-run are ignored.
- rst mid-run: immediate return to IDLE with all reset values; a transfer in that cycle is discarded.

Optional Feature:
- Macro: OPERAND_STREAM_GEN_GAP_EN.
- With the macro: adds input `gap` [3:0], latched on start. After each transfer, valid drops for `gap` cycles (internal GAP countdown substate of RUN) before the next triple. gap==0 is identical to back-to-back.
- Without the macro: no port and no gap logic; back-to-back as specified above.

Decomposition:
- Package `operand_stream_pkg`:
  - enum mode_e (MODE_LFSR, MODE_CONST, MODE_RAMP, MODE_ZERO);
  - enum state_e (IDLE, RUN, DONE);
  - localparam DEFAULT_POLY.
- Sub-module `galois_lfsr_step`: combinational, WIDTH/POLY params, in x, out step(x). Instantiated three times: b, c, and step^3 for the next s.

Test Plan:
- Reset, then start with count=0 -> no valid; done pulses at N+1; issued=0; busy high for exactly one cycle.
- RAMP, count=3, ready=1 -> (0,1,2), (1,2,3), (2,3,4) on consecutive cycles from N+1; done the cycle after the third; issued=3.
- LFSR, SEED=1, count=1 -> a=32'h00000001, b=32'h80200003, c=32'hC0300002.
- CONST with default SEED, count=4, ready toggling 1,0,0,1,... -> a=b=c=200 held stable while !ready; exactly 4 transfers; done once.
- RAMP, count=8, rst asserted after 2 transfers -> outputs zero immediately; a new start runs cleanly from k=0.
- With OPERAND_STREAM_GEN_GAP_EN, gap=2, count=2, ready=1 -> valid pattern 1,0,0,1; done follows.
